// File: rtl/check_data_mc_if.sv
// ----------------------------------------------------------------------------
// check_data_mc_if
// Stream bundle between the capture-memory test harness and the checker.
//
// Handshake: in_valid qualifies data_in and data_out in the cycle it is high.
// There is no ready, because the checker always accepts. start is a
// single-cycle pulse that does not depend on in_valid.
//
// Signals:
//   start     - single-cycle pulse that clears the results and arms the checker
//   in_valid  - data_in/data_out are meaningful this cycle
//   data_in   - memory input stream, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_out  - memory output stream, same packing
// Modports: master drives the stream, slave (the checker) observes it.
// ----------------------------------------------------------------------------
interface check_data_mc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2
);
    logic                         start;
    logic                         in_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic [NUM_CH*DATA_WIDTH-1:0] data_out;

    modport master (output start, output in_valid, output data_in, output data_out);
    modport slave  (input  start, input  in_valid, input  data_in, input  data_out);
endinterface

// File: rtl/check_data_mc.sv
// ----------------------------------------------------------------------------
// check_data_mc
// Multi-channel circular-buffer read/write checker. After a start pulse it
// counts valid samples. Once the holdoff and buffer-fill latency have passed,
// it compares each channel of the memory output against the memory input for
// a window of MEMORY_SIZE samples.
//
// Ports:
//   clk, rst_n       - clock; asynchronous active-low reset
//   bus (slave)      - start / in_valid / data_in / data_out
//   busy             - checker armed (WAIT or CHECK)
//   done             - window complete; held until the next start
//   test_failed      - sticky: any mismatch since the last start
//   fail_mask        - sticky per-channel mismatch flags
//   error_count      - failing channel-samples, saturating
//   first_err_index  - sample index of the first mismatch (0 = none)
//   dbg_state        - current FSM state encoding
//
// Optional feature (macro CHECK_DATA_MC_CAPTURE_EN):
//   first_err_channel  - lowest failing channel at the first error
//   first_err_expected - value data_out should have held (data_in - OFFSET)
//   first_err_actual   - value data_out actually held
// ----------------------------------------------------------------------------
module check_data_mc #(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_CH          = 2,
    parameter int MEMORY_SIZE     = 16,
    parameter int ALIGNMENT_DELAY = 2,
    parameter int USER_HOLDOFF    = 4,
    parameter int CNT_WIDTH       = 16,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    check_data_mc_if.slave        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  test_failed,
    output logic [NUM_CH-1:0]     fail_mask,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [CNT_WIDTH-1:0]  first_err_index,
`ifdef CHECK_DATA_MC_CAPTURE_EN
    output logic [CH_W-1:0]       first_err_channel,
    output logic [DATA_WIDTH-1:0] first_err_expected,
    output logic [DATA_WIDTH-1:0] first_err_actual,
`endif
    output logic [1:0]            dbg_state
);

    localparam int OFFSET = MEMORY_SIZE + ALIGNMENT_DELAY + 1;
    localparam int WIN_LO = USER_HOLDOFF + OFFSET;
    localparam int WIN_HI = WIN_LO + MEMORY_SIZE;

    localparam logic [DATA_WIDTH-1:0] OFF_D   = DATA_WIDTH'(OFFSET);
    localparam logic [CNT_WIDTH-1:0]  WIN_LO_C = CNT_WIDTH'(WIN_LO);
    localparam logic [CNT_WIDTH-1:0]  WIN_HI_C = CNT_WIDTH'(WIN_HI);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_WIDTH:0]    SUM_ONE  = 1;

    // The sample counter has to reach WIN_HI without saturating.
    if (CNT_WIDTH <= $clog2(WIN_HI + 1)) begin : g_cnt_width_check
        $error("check_data_mc: CNT_WIDTH too small for WIN_HI");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   n_q, n_d;
    logic                   test_failed_q, test_failed_d;
    logic [NUM_CH-1:0]      fail_mask_q, fail_mask_d;
    logic [CNT_WIDTH-1:0]   error_count_q, error_count_d;
    logic [CNT_WIDTH-1:0]   first_err_index_q, first_err_index_d;

    logic [NUM_CH-1:0]      mismatch;
    logic [CNT_WIDTH-1:0]   n_inc;
    logic [CNT_WIDTH:0]     err_sum;

`ifdef CHECK_DATA_MC_CAPTURE_EN
    logic [CH_W-1:0]        first_err_channel_q, first_err_channel_d;
    logic [DATA_WIDTH-1:0]  first_err_expected_q, first_err_expected_d;
    logic [DATA_WIDTH-1:0]  first_err_actual_q, first_err_actual_d;
    logic [CH_W-1:0]        low_ch;
    logic [DATA_WIDTH-1:0]  low_exp;
    logic [DATA_WIDTH-1:0]  low_act;
`endif

    always_comb begin
        state_d           = state_q;
        n_d               = n_q;
        test_failed_d     = test_failed_q;
        fail_mask_d       = fail_mask_q;
        error_count_d     = error_count_q;
        first_err_index_d = first_err_index_q;
`ifdef CHECK_DATA_MC_CAPTURE_EN
        first_err_channel_d  = first_err_channel_q;
        first_err_expected_d = first_err_expected_q;
        first_err_actual_d   = first_err_actual_q;
        low_ch  = '0;
        low_exp = '0;
        low_act = '0;
`endif

        // The addition is truncated to DATA_WIDTH, so counter patterns that
        // wrap past all-ones still compare correctly.
        mismatch = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mismatch[c] = (bus.data_out[c*DATA_WIDTH +: DATA_WIDTH] + OFF_D)
                          != bus.data_in[c*DATA_WIDTH +: DATA_WIDTH];
        end

`ifdef CHECK_DATA_MC_CAPTURE_EN
        // Scan from the top down so the lowest failing channel wins.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (mismatch[c]) begin
                low_ch  = CH_W'(c);
                low_exp = bus.data_in[c*DATA_WIDTH +: DATA_WIDTH] - OFF_D;
                low_act = bus.data_out[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
`endif

        n_inc = (n_q == '1) ? n_q : n_q + CNT_ONE;

        // The sum is one bit wider than the counter, so overflow shows up
        // in the top bit and can be clamped to all-ones.
        err_sum = {1'b0, error_count_q};
        for (int c = 0; c < NUM_CH; c++) begin
            if (mismatch[c]) err_sum = err_sum + SUM_ONE;
        end

        case (state_q)
            S_WAIT: begin
                if (bus.in_valid) begin
                    n_d = n_inc;
                    if (n_inc == WIN_LO_C) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus.in_valid) begin
                    n_d = n_inc;
                    if (n_inc > WIN_LO_C && n_inc <= WIN_HI_C && |mismatch) begin
                        test_failed_d = 1'b1;
                        fail_mask_d   = fail_mask_q | mismatch;
                        error_count_d = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
                        if (first_err_index_q == '0) begin
                            first_err_index_d = n_inc;
`ifdef CHECK_DATA_MC_CAPTURE_EN
                            first_err_channel_d  = low_ch;
                            first_err_expected_d = low_exp;
                            first_err_actual_d   = low_act;
`endif
                        end
                    end
                    if (n_inc == WIN_HI_C) state_d = S_DONE;
                end
            end
            default: ;  // IDLE and DONE ignore data
        endcase

        // start overrides everything, including the last window sample.
        if (bus.start) begin
            state_d           = S_WAIT;
            n_d               = '0;
            test_failed_d     = 1'b0;
            fail_mask_d       = '0;
            error_count_d     = '0;
            first_err_index_d = '0;
`ifdef CHECK_DATA_MC_CAPTURE_EN
            first_err_channel_d  = '0;
            first_err_expected_d = '0;
            first_err_actual_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            n_q               <= '0;
            test_failed_q     <= 1'b0;
            fail_mask_q       <= '0;
            error_count_q     <= '0;
            first_err_index_q <= '0;
`ifdef CHECK_DATA_MC_CAPTURE_EN
            first_err_channel_q  <= '0;
            first_err_expected_q <= '0;
            first_err_actual_q   <= '0;
`endif
        end else begin
            state_q           <= state_d;
            n_q               <= n_d;
            test_failed_q     <= test_failed_d;
            fail_mask_q       <= fail_mask_d;
            error_count_q     <= error_count_d;
            first_err_index_q <= first_err_index_d;
`ifdef CHECK_DATA_MC_CAPTURE_EN
            first_err_channel_q  <= first_err_channel_d;
            first_err_expected_q <= first_err_expected_d;
            first_err_actual_q   <= first_err_actual_d;
`endif
        end
    end

    assign busy            = (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done            = (state_q == S_DONE);
    assign test_failed     = test_failed_q;
    assign fail_mask       = fail_mask_q;
    assign error_count     = error_count_q;
    assign first_err_index = first_err_index_q;
    assign dbg_state       = state_q;
`ifdef CHECK_DATA_MC_CAPTURE_EN
    assign first_err_channel  = first_err_channel_q;
    assign first_err_expected = first_err_expected_q;
    assign first_err_actual   = first_err_actual_q;
`endif

endmodule

// File: tb/tb_check_data_mc.sv
// ----------------------------------------------------------------------------
// tb_check_data_mc
// Directed bench for check_data_mc with default parameters
// (OFFSET = 19, window = samples 24..39). The bench drives inputs on the
// falling edge and samples outputs 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_check_data_mc;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        done;
    logic        test_failed;
    logic [1:0]  fail_mask;
    logic [15:0] error_count;
    logic [15:0] first_err_index;
    logic [1:0]  dbg_state;
`ifdef CHECK_DATA_MC_CAPTURE_EN
    logic [0:0]  first_err_channel;
    logic [7:0]  first_err_expected;
    logic [7:0]  first_err_actual;
`endif

    int tests_run;
    int tests_failed;

    check_data_mc_if #(.DATA_WIDTH(8), .NUM_CH(2)) bus ();

    check_data_mc dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .busy            (busy),
        .done            (done),
        .test_failed     (test_failed),
        .fail_mask       (fail_mask),
        .error_count     (error_count),
        .first_err_index (first_err_index),
`ifdef CHECK_DATA_MC_CAPTURE_EN
        .first_err_channel  (first_err_channel),
        .first_err_expected (first_err_expected),
        .first_err_actual   (first_err_actual),
`endif
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input logic tf, input logic [1:0] fm,
                                 input logic [15:0] ec, input logic [15:0] fi);
        check_val({tag, "_test_failed"}, 32'(test_failed), 32'(tf));
        check_val({tag, "_fail_mask"}, 32'(fail_mask), 32'(fm));
        check_val({tag, "_error_count"}, 32'(error_count), 32'(ec));
        check_val({tag, "_first_err_index"}, 32'(first_err_index), 32'(fi));
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic st, input logic v,
                        input logic [7:0] i0, input logic [7:0] i1,
                        input logic [7:0] o0, input logic [7:0] o1);
        @(negedge clk);
        bus.start    = st;
        bus.in_valid = v;
        bus.data_in  = {i1, i0};
        bus.data_out = {o1, o0};
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        send(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    // Sends samples n = 1..last_n of a counter pattern (data_in = base + n,
    // data_out = data_in - 19). Data_out is corrupted by +1 at samples
    // b0/b1/b2 on the channels set in bad_mask. If toggle is set, an invalid
    // cycle carrying garbage is inserted before each sample.
    task automatic run_window(input string tag, input int base, input bit toggle,
                              input int b0, input int b1, input int b2,
                              input logic [1:0] bad_mask, input int last_n);
        logic [7:0] di, dv, o0, o1;
        for (int n = 1; n <= last_n; n++) begin
            if (toggle) send(1'b0, 1'b0, 8'hA5, 8'h5A, 8'h00, 8'hFF);
            di = 8'(base + n);
            dv = di - 8'd19;
            o0 = dv;
            o1 = dv;
            if (n == b0 || n == b1 || n == b2) begin
                if (bad_mask[0]) o0 = dv + 8'd1;
                if (bad_mask[1]) o1 = dv + 8'd1;
            end
            send(1'b0, 1'b1, di, di, o0, o1);
            check_val({tag, "_busy"}, 32'(busy), 32'(n < 39));
            check_val({tag, "_done"}, 32'(done), 32'(n == 39));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        bus.data_out = '0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'd0);
        check_results("rst", 1'b0, 2'b00, 16'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Data is ignored while idle.
        send(1'b0, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_state", 32'(dbg_state), 32'd0);

        // 1: clean counter run
        pulse_start();
        check_val("s1_armed_busy", 32'(busy), 32'd1);
        check_val("s1_armed_state", 32'(dbg_state), 32'd1);
        run_window("s1", 0, 1'b0, 0, 0, 0, 2'b00, 39);
        check_results("s1", 1'b0, 2'b00, 16'd0, 16'd0);
        send(1'b0, 1'b1, 8'h00, 8'h00, 8'h55, 8'h55);
        check_val("s1_done_held", 32'(done), 32'd1);
        check_val("s1_frozen_ec", 32'(error_count), 32'd0);

        // 2: channel 1 corrupted at n = 30
        pulse_start();
        run_window("s2", 0, 1'b0, 30, 0, 0, 2'b10, 39);
        check_results("s2", 1'b1, 2'b10, 16'd1, 16'd30);
`ifdef CHECK_DATA_MC_CAPTURE_EN
        check_val("s2_err_ch", 32'(first_err_channel), 32'd1);
        check_val("s2_err_exp", 32'(first_err_expected), 32'd11);
        check_val("s2_err_act", 32'(first_err_actual), 32'd12);
`endif

        // 3: both channels wrong at 10 (ignored), 24 and 39
        pulse_start();
        check_results("s3_clear", 1'b0, 2'b00, 16'd0, 16'd0);
        run_window("s3", 0, 1'b0, 10, 24, 39, 2'b11, 39);
        check_results("s3", 1'b1, 2'b11, 16'd4, 16'd24);
`ifdef CHECK_DATA_MC_CAPTURE_EN
        check_val("s3_err_ch", 32'(first_err_channel), 32'd0);
`endif

        // 4: in_valid every other cycle, counter wraps past 255
        pulse_start();
        run_window("s4", 240, 1'b1, 0, 0, 0, 2'b00, 39);
        check_results("s4", 1'b0, 2'b00, 16'd0, 16'd0);

        // 5: error at 25, restart pulsed together with sample 28
        pulse_start();
        run_window("s5a", 0, 1'b0, 25, 0, 0, 2'b01, 27);
        check_results("s5a", 1'b1, 2'b01, 16'd1, 16'd25);
        send(1'b1, 1'b1, 8'd28, 8'd28, 8'd0, 8'd0);
        check_val("s5_restart_state", 32'(dbg_state), 32'd1);
        check_results("s5_restart", 1'b0, 2'b00, 16'd0, 16'd0);
        run_window("s5b", 0, 1'b0, 0, 0, 0, 2'b00, 39);
        check_results("s5b", 1'b0, 2'b00, 16'd0, 16'd0);

        // 6: start together with a corrupted final sample: start wins
        pulse_start();
        run_window("s6a", 0, 1'b0, 0, 0, 0, 2'b00, 38);
        send(1'b1, 1'b1, 8'd39, 8'd39, 8'd99, 8'd99);
        check_val("s6_busy", 32'(busy), 32'd1);
        check_val("s6_done", 32'(done), 32'd0);
        check_val("s6_state", 32'(dbg_state), 32'd1);
        check_results("s6", 1'b0, 2'b00, 16'd0, 16'd0);
        run_window("s6b", 0, 1'b0, 0, 0, 0, 2'b00, 39);

        // 7: reset asserted mid-CHECK
        pulse_start();
        run_window("s7", 0, 1'b0, 25, 0, 0, 2'b11, 29);
        check_results("s7_pre", 1'b1, 2'b11, 16'd2, 16'd25);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("s7_rst_busy", 32'(busy), 32'd0);
        check_val("s7_rst_done", 32'(done), 32'd0);
        check_val("s7_rst_state", 32'(dbg_state), 32'd0);
        check_results("s7_rst", 1'b0, 2'b00, 16'd0, 16'd0);
`ifdef CHECK_DATA_MC_CAPTURE_EN
        check_val("s7_rst_err_act", 32'(first_err_actual), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(1'b0, 1'b1, 8'd30, 8'd30, 8'd0, 8'd0);
        end
        check_val("s7_after_busy", 32'(busy), 32'd0);
        check_val("s7_after_state", 32'(dbg_state), 32'd0);
        check_results("s7_after", 1'b0, 2'b00, 16'd0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
